risc_dmem: RTL and testbench

RISC_DMEM -- requirements
Module: risc_dmem

---
 rtl/risc_dmem.sv | 109 ++++++++++
 tb/tb_risc_dmem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/risc_dmem.sv
// Flip-flop data memory for a small RISC core, with a streaming preload mode
// and saturating CPU read/write access counters.
module risc_dmem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dmenbl,
    input  logic          rdwr,
    input  logic [AW-1:0] dmaddr,
    input  logic [DW-1:0] dmdatain,
    output logic [DW-1:0] dmdataout,
    input  logic          init_start,
    input  logic          init_valid,
    input  logic [DW-1:0] init_data,
    output logic          init_busy,
    output logic          init_done,
    output logic [7:0]    rd_cnt,
    output logic [7:0]    wr_cnt
);

    typedef enum logic [0:0] {StRun, StLoad} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] load_cnt_q, load_cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] dout_q, dout_d;
    logic          done_q, done_d;
    logic [7:0]    rd_cnt_q, rd_cnt_d;
    logic [7:0]    wr_cnt_q, wr_cnt_d;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        mem_d      = mem_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        unique case (state_q)
            StRun: begin
                if (dmenbl) begin
                    if (rdwr) begin
                        dout_d = mem_q[dmaddr];
                        if (rd_cnt_q != 8'hFF) begin
                            rd_cnt_d = rd_cnt_q + 8'd1;
                        end
                    end else begin
                        mem_d[dmaddr] = dmdatain;
                        if (wr_cnt_q != 8'hFF) begin
                            wr_cnt_d = wr_cnt_q + 8'd1;
                        end
                    end
                end
                // A CPU access in the same cycle still completes above.
                if (init_start) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                end
            end
            StLoad: begin
                if (init_valid) begin
                    mem_d[load_cnt_q] = init_data;
                    if (load_cnt_q == AW'(DEPTH - 1)) begin
                        state_d    = StRun;
                        load_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + AW'(1);
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            load_cnt_q <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign dmdataout = dout_q;
    assign init_busy = (state_q == StLoad);
    assign init_done = done_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_risc_dmem.sv
// Directed self-checking bench for risc_dmem: CPU access, preload, reset abort
// and counter saturation.
module tb_risc_dmem;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dmenbl;
    logic          rdwr;
    logic [AW-1:0] dmaddr;
    logic [DW-1:0] dmdatain;
    logic [DW-1:0] dmdataout;
    logic          init_start;
    logic          init_valid;
    logic [DW-1:0] init_data;
    logic          init_busy;
    logic          init_done;
    logic [7:0]    rd_cnt;
    logic [7:0]    wr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    risc_dmem #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmenbl    (dmenbl),
        .rdwr      (rdwr),
        .dmaddr    (dmaddr),
        .dmdatain  (dmdatain),
        .dmdataout (dmdataout),
        .init_start(init_start),
        .init_valid(init_valid),
        .init_data (init_data),
        .init_busy (init_busy),
        .init_done (init_done),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic en, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        dmenbl   = en;
        rdwr     = rw;
        dmaddr   = a;
        dmdatain = d;
    endtask

    task automatic read_expect(input string tag, input logic [AW-1:0] a,
                               input logic [DW-1:0] exp);
        cpu(1'b1, 1'b1, a, 8'h00);
        tick();
        cpu(1'b0, 1'b1, 4'h0, 8'h00);
        check(tag, dmdataout, exp);
    endtask

    initial begin
        int w;
        int k;
        int pulses;

        rst_n      = 1'b0;
        init_start = 1'b0;
        init_valid = 1'b0;
        init_data  = '0;
        cpu(1'b0, 1'b1, 4'h0, 8'h00);
        #1;
        check("rst_dout", dmdataout, 0);
        check("rst_busy", init_busy, 0);
        check("rst_done", init_done, 0);
        check("rst_rdcnt", rd_cnt, 0);
        check("rst_wrcnt", wr_cnt, 0);
        #13;
        rst_n = 1'b1;
        tick();

        // Reset contents read back as zero
        for (int i = 0; i < 16; i++) begin
            read_expect("rst_mem", AW'(i), 8'h00);
        end
        check("rd16_rdcnt", rd_cnt, 16);
        check("rd16_wrcnt", wr_cnt, 0);

        rst_n = 1'b0;
        #2;
        check("rst2_rdcnt", rd_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Write then read-after-write
        cpu(1'b1, 1'b0, 4'd3, 8'hA5);
        tick();
        check("wr_dout_hold0", dmdataout, 8'h00);
        read_expect("raw_a5", 4'd3, 8'hA5);
        check("raw_wrcnt", wr_cnt, 1);
        check("raw_rdcnt", rd_cnt, 1);
        cpu(1'b1, 1'b0, 4'd3, 8'h3C);
        tick();
        check("wr_dout_hold", dmdataout, 8'hA5);
        cpu(1'b0, 1'b1, 4'd3, 8'h00);
        tick();
        check("idle_dout_hold", dmdataout, 8'hA5);
        check("idle_rdcnt", rd_cnt, 1);

        // Preload with gaps, CPU traffic and a stray init_start during LOAD
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("load_enter_busy", init_busy, 1);
        check("load_enter_done", init_done, 0);
        w = 0;
        k = 0;
        pulses = 0;
        while (w < 16 && k < 100) begin
            dmenbl     = 1'b1;
            rdwr       = k[0];
            dmaddr     = 4'd0;
            dmdatain   = 8'hFF;
            init_start = (k == 5);
            if (k % 3 == 2) begin
                init_valid = 1'b0;
            end else begin
                init_valid = 1'b1;
                init_data  = 8'(8'h10 + w);
            end
            tick();
            if (init_valid) w++;
            if (init_done) pulses++;
            check("load_busy", init_busy, (w < 16));
            check("load_done", init_done, (w == 16));
            check("load_dout_hold", dmdataout, 8'hA5);
            k++;
        end
        check("load_complete", w, 16);
        cpu(1'b0, 1'b1, 4'd0, 8'h00);
        init_start = 1'b0;
        init_valid = 1'b0;
        tick();
        check("done_one_cycle", init_done, 0);
        check("done_pulses", pulses, 1);
        check("load_rdcnt", rd_cnt, 1);
        check("load_wrcnt", wr_cnt, 2);
        for (int i = 0; i < 16; i++) begin
            read_expect("preload_mem", AW'(i), 8'(8'h10 + i));
        end
        check("post_load_rdcnt", rd_cnt, 17);

        // CPU read and init_start in the same RUN cycle, then reset mid-preload
        cpu(1'b1, 1'b1, 4'd5, 8'h00);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        cpu(1'b0, 1'b1, 4'd0, 8'h00);
        check("same_cyc_dout", dmdataout, 8'h15);
        check("same_cyc_busy", init_busy, 1);
        check("same_cyc_rdcnt", rd_cnt, 18);
        for (int i = 0; i < 8; i++) begin
            init_valid = 1'b1;
            init_data  = 8'(8'h40 + i);
            tick();
        end
        init_valid = 1'b0;
        check("part_load_busy", init_busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", init_busy, 0);
        check("abort_dout", dmdataout, 0);
        check("abort_rdcnt", rd_cnt, 0);
        #3;
        rst_n = 1'b1;
        tick();
        read_expect("abort_mem0", 4'd0, 8'h00);
        read_expect("abort_mem7", 4'd7, 8'h00);
        check("abort_run_busy", init_busy, 0);

        // Write counter saturation
        for (int i = 0; i < 300; i++) begin
            cpu(1'b1, 1'b0, AW'(i % 16), 8'(i));
            tick();
            if (i == 253) check("wrcnt_254", wr_cnt, 254);
        end
        cpu(1'b0, 1'b1, 4'd0, 8'h00);
        check("wrcnt_sat", wr_cnt, 255);
        read_expect("sat_last_wr", 4'd11, 8'h2B);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
